// File: rtl/rail_seq_ctrl_pkg.sv
// Shared power-sequencing definitions: sequencer state and fault codes,
// default timing constants and a small sizing helper.
package rail_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        SEQ_OFF      = 3'd0,
        SEQ_WAIT_PG  = 3'd1,
        SEQ_ON_DLY   = 3'd2,
        SEQ_ON       = 3'd3,
        SEQ_SHUTDOWN = 3'd4,
        SEQ_FAULT    = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        FC_NONE       = 2'd0,
        FC_PG_TIMEOUT = 2'd1,
        FC_PG_DROP    = 2'd2,
        FC_RESERVED   = 2'd3
    } fault_code_e;

    localparam int DEF_N_RAILS   = 4;
    localparam int DEF_T_PG_TO   = 100;
    localparam int DEF_T_ON_DLY  = 10;
    localparam int DEF_T_OFF_DLY = 5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rail_seq_ctrl_seq_timer.sv
// Saturating cycle counter with synchronous clear and a terminal-count
// flag compared against a runtime limit.
module seq_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         done
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count;

    // Holds at all-ones rather than wrapping so a stale count never re-matches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == limit);

endmodule

// File: rtl/rail_seq_ctrl.sv
// Main-rail power sequencer: brings rails up in order once the active-sleep
// well is good, supervises their power-good and shuts them down or trips.
module rail_seq_ctrl
    import rail_seq_ctrl_pkg::*;
#(
    parameter int N_RAILS   = DEF_N_RAILS,
    parameter int T_PG_TO   = DEF_T_PG_TO,
    parameter int T_ON_DLY  = DEF_T_ON_DLY,
    parameter int T_OFF_DLY = DEF_T_OFF_DLY
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               asw_ok,
    input  logic               pwr_on_req,
    input  logic [N_RAILS-1:0] rail_pwrgd,
    output logic [N_RAILS-1:0] rail_en,
    output logic               sys_pwrok,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [2:0]         fault_rail,
    output logic [2:0]         seq_fsm
);

    localparam int TW = $clog2(max3(T_PG_TO, T_ON_DLY, T_OFF_DLY) + 1);

    localparam logic [2:0] ST_OFF      = SEQ_OFF;
    localparam logic [2:0] ST_WAIT_PG  = SEQ_WAIT_PG;
    localparam logic [2:0] ST_ON_DLY   = SEQ_ON_DLY;
    localparam logic [2:0] ST_ON       = SEQ_ON;
    localparam logic [2:0] ST_SHUTDOWN = SEQ_SHUTDOWN;
    localparam logic [2:0] ST_FAULT    = SEQ_FAULT;

    localparam logic [TW-1:0]      LIM_PG   = TW'(T_PG_TO - 1);
    localparam logic [TW-1:0]      LIM_ON   = TW'(T_ON_DLY - 1);
    localparam logic [TW-1:0]      LIM_OFF  = TW'(T_OFF_DLY - 1);
    localparam logic [N_RAILS-1:0] RAIL0    = N_RAILS'(1);
    localparam logic [2:0]         LAST_IDX = 3'(N_RAILS - 1);

    logic [2:0]         state, state_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [N_RAILS-1:0] en_nxt, idx_mask, good_mask, dropped;
    logic               fault_nxt;
    logic [1:0]         code_nxt;
    logic [2:0]         frail_nxt;
    logic               drop_any;
    logic [2:0]         drop_rail;
    logic               cur_pg;
    logic               tmr_done, tmr_clear;
    logic [TW-1:0]      tmr_limit;

    assign idx_mask = RAIL0 << idx;
    assign cur_pg   = |(rail_pwrgd & idx_mask);

    // Rails already proven good; the current rail only counts once past WAIT_PG.
    always_comb begin
        good_mask = '0;
        if (state == ST_WAIT_PG) begin
            good_mask = idx_mask - RAIL0;
        end else if ((state == ST_ON_DLY) || (state == ST_ON)) begin
            good_mask = (idx_mask - RAIL0) | idx_mask;
        end
        dropped   = good_mask & ~rail_pwrgd;
        drop_any  = |dropped;
        drop_rail = '0;
        for (int j = N_RAILS - 1; j >= 0; j--) begin
            if (dropped[j]) drop_rail = 3'(j);
        end
    end

    always_comb begin
        case (state)
            ST_WAIT_PG:  tmr_limit = LIM_PG;
            ST_ON_DLY:   tmr_limit = LIM_ON;
            ST_SHUTDOWN: tmr_limit = LIM_OFF;
            default:     tmr_limit = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        en_nxt    = rail_en;
        fault_nxt = fault;
        code_nxt  = fault_code;
        frail_nxt = fault_rail;
        if (!asw_ok && (state != ST_OFF)) begin
            state_nxt = ST_OFF;
            idx_nxt   = '0;
            en_nxt    = '0;
        end else if (drop_any) begin
            state_nxt = ST_FAULT;
            en_nxt    = '0;
            fault_nxt = 1'b1;
            code_nxt  = FC_PG_DROP;
            frail_nxt = drop_rail;
        end else if ((state == ST_WAIT_PG) && !cur_pg && tmr_done) begin
            state_nxt = ST_FAULT;
            en_nxt    = '0;
            fault_nxt = 1'b1;
            code_nxt  = FC_PG_TIMEOUT;
            frail_nxt = idx;
        end else if (!pwr_on_req &&
                     ((state == ST_WAIT_PG) || (state == ST_ON_DLY) || (state == ST_ON))) begin
            state_nxt = ST_SHUTDOWN;
            en_nxt    = rail_en & ~idx_mask;
        end else begin
            case (state)
                ST_OFF: begin
                    en_nxt  = '0;
                    idx_nxt = '0;
                    if (pwr_on_req && asw_ok) begin
                        state_nxt = ST_WAIT_PG;
                        en_nxt    = RAIL0;
                    end
                end
                ST_WAIT_PG: begin
                    if (cur_pg) state_nxt = (idx == LAST_IDX) ? ST_ON : ST_ON_DLY;
                end
                ST_ON_DLY: begin
                    if (tmr_done) begin
                        state_nxt = ST_WAIT_PG;
                        idx_nxt   = idx + 3'd1;
                        en_nxt    = rail_en | (idx_mask << 1);
                    end
                end
                ST_ON: ;
                ST_SHUTDOWN: begin
                    if (tmr_done) begin
                        if (idx == 3'd0) begin
                            state_nxt = ST_OFF;
                        end else begin
                            idx_nxt = idx - 3'd1;
                            en_nxt  = rail_en & ~(idx_mask >> 1);
                        end
                    end
                end
                ST_FAULT: begin
                    en_nxt = '0;
                    if (!pwr_on_req) begin
                        state_nxt = ST_OFF;
                        idx_nxt   = '0;
                        fault_nxt = 1'b0;
                        code_nxt  = FC_NONE;
                        frail_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    idx_nxt   = '0;
                    en_nxt    = '0;
                end
            endcase
        end
    end

    assign tmr_clear = (state_nxt != state) || (idx_nxt != idx);

    seq_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (1'b1),
        .limit  (tmr_limit),
        .done   (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            idx        <= '0;
            rail_en    <= '0;
            sys_pwrok  <= 1'b0;
            fault      <= 1'b0;
            fault_code <= '0;
            fault_rail <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            rail_en    <= en_nxt;
            sys_pwrok  <= (state == ST_ON);
            fault      <= fault_nxt;
            fault_code <= code_nxt;
            fault_rail <= frail_nxt;
        end
    end

    assign seq_fsm = state;

endmodule

// File: tb/tb_rail_seq_ctrl.sv
// Bench for rail_seq_ctrl: directed power-up table, randomized pwrgd delays
// against a timeline model, and hand-written drop/off/asw/reset sequences.
module tb_rail_seq_ctrl;

    localparam int N         = 4;
    localparam int T_PG_TO   = 100;
    localparam int T_ON_DLY  = 10;
    localparam int T_OFF_DLY = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         asw_ok = 1'b0;
    logic         pwr_on_req = 1'b0;
    logic [N-1:0] rail_pwrgd = '0;
    logic [N-1:0] rail_en;
    logic         sys_pwrok;
    logic         fault;
    logic [1:0]   fault_code;
    logic [2:0]   fault_rail;
    logic [2:0]   seq_fsm;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rail_seq_ctrl #(
        .N_RAILS(N), .T_PG_TO(T_PG_TO), .T_ON_DLY(T_ON_DLY), .T_OFF_DLY(T_OFF_DLY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .asw_ok     (asw_ok),
        .pwr_on_req (pwr_on_req),
        .rail_pwrgd (rail_pwrgd),
        .rail_en    (rail_en),
        .sys_pwrok  (sys_pwrok),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_rail (fault_rail),
        .seq_fsm    (seq_fsm)
    );

    typedef struct {
        logic [N-1:0][7:0] dly;
        bit                exp_fault;
        int                exp_rail;
        int                exp_end;
    } vec_t;

    vec_t vecs[6];

    int act_en_t[N];
    int act_end;
    bit act_fault;
    int exp_en_t[N];
    int exp_end;
    bit exp_fault;
    int exp_rail;

    function automatic vec_t mk(input int d0, input int d1, input int d2, input int d3,
                                input bit f, input int r, input int e);
        vec_t v;
        v.dly       = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        v.exp_fault = f;
        v.exp_rail  = r;
        v.exp_end   = e;
        return v;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Powers up from OFF; each rail's pwrgd rises dly[k] clocks after its enable.
    // Cycle 1 is the first edge after the request. Stops at fault or sys_pwrok.
    task automatic apply_stimulus(input logic [N-1:0][7:0] dly);
        logic [N-1:0] prev_en;
        for (int k = 0; k < N; k++) act_en_t[k] = -1;
        act_end   = -1;
        act_fault = 1'b0;
        prev_en   = rail_en;
        asw_ok     = 1'b1;
        pwr_on_req = 1'b1;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (rail_en[k] && !prev_en[k]) act_en_t[k] = cyc;
                if ((act_en_t[k] >= 0) && (cyc - act_en_t[k] == int'(dly[k])))
                    rail_pwrgd[k] = 1'b1;
            end
            prev_en = rail_en;
            if (fault) begin
                act_fault = 1'b1;
                act_end   = cyc;
                break;
            end
            if (sys_pwrok) begin
                act_end = cyc;
                break;
            end
        end
    endtask

    // Timeline model: rail k is enabled at t_k; good after d cycles means
    // detect at t_k+d+1, next enable T_ON_DLY later, or timeout at t_k+T_PG_TO.
    task automatic model_powerup(input logic [N-1:0][7:0] dly);
        int  t;
        bit  stop;
        t    = 1;
        stop = 1'b0;
        for (int k = 0; k < N; k++) exp_en_t[k] = -1;
        exp_fault = 1'b0;
        exp_rail  = 0;
        exp_end   = -1;
        for (int k = 0; k < N; k++) begin
            if (!stop) begin
                exp_en_t[k] = t;
                if (int'(dly[k]) >= T_PG_TO) begin
                    exp_fault = 1'b1;
                    exp_rail  = k;
                    exp_end   = t + T_PG_TO;
                    stop      = 1'b1;
                end else if (k == N - 1) begin
                    exp_end = t + int'(dly[k]) + 2;
                end else begin
                    t = t + int'(dly[k]) + 1 + T_ON_DLY;
                end
            end
        end
    endtask

    task automatic check_outcome(input string name, input bit f, input int r, input int e);
        check_output({name, "_fault"}, int'(act_fault), int'(f));
        check_output({name, "_end"}, act_end, e);
        check_output({name, "_rail_en"}, int'(rail_en), f ? 0 : 15);
        if (f) begin
            check_output({name, "_code"}, int'(fault_code), 1);
            check_output({name, "_frail"}, int'(fault_rail), r);
        end
    endtask

    task automatic go_off();
        pwr_on_req = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_output("go_off_state", int'(seq_fsm), 0);
        check_output("go_off_fault", int'(fault), 0);
        rail_pwrgd = '0;
        asw_ok     = 1'b1;
    endtask

    task automatic check_reset_values(input string name);
        check_output({name, "_rail_en"}, int'(rail_en), 0);
        check_output({name, "_pwrok"}, int'(sys_pwrok), 0);
        check_output({name, "_fault"}, int'(fault), 0);
        check_output({name, "_code"}, int'(fault_code), 0);
        check_output({name, "_frail"}, int'(fault_rail), 0);
        check_output({name, "_state"}, int'(seq_fsm), 0);
    endtask

    initial begin
        logic [N-1:0][7:0] rdly;

        vecs[0] = mk(3, 3, 3, 3, 1'b0, 0, 48);
        vecs[1] = mk(3, 3, 200, 0, 1'b1, 2, 129);
        vecs[2] = mk(99, 0, 0, 0, 1'b0, 0, 135);
        vecs[3] = mk(100, 0, 0, 0, 1'b1, 0, 101);
        vecs[4] = mk(0, 5, 99, 100, 1'b1, 3, 238);
        vecs[5] = mk(0, 0, 0, 99, 1'b0, 0, 135);

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vecs[v].dly);
            check_outcome($sformatf("vec%0d", v), vecs[v].exp_fault, vecs[v].exp_rail,
                          vecs[v].exp_end);
            go_off();
        end

        apply_stimulus(vecs[0].dly);
        check_output("nominal_en1_t", act_en_t[1], 15);
        check_output("nominal_en3_t", act_en_t[3], 43);

        // Rail 1 glitches low for one clock while fully on.
        rail_pwrgd[1] = 1'b0;
        @(posedge clk); #1;
        rail_pwrgd[1] = 1'b1;
        check_output("drop_rail_en", int'(rail_en), 0);
        check_output("drop_fault", int'(fault), 1);
        check_output("drop_code", int'(fault_code), 2);
        check_output("drop_frail", int'(fault_rail), 1);
        check_output("drop_state", int'(seq_fsm), 5);
        check_output("drop_pwrok_lag", int'(sys_pwrok), 1);
        @(posedge clk); #1;
        check_output("drop_pwrok_fall", int'(sys_pwrok), 0);
        repeat (3) @(posedge clk);
        #1;
        check_output("fault_hold", int'(fault), 1);
        pwr_on_req = 1'b0;
        @(posedge clk); #1;
        check_output("fault_exit_state", int'(seq_fsm), 0);
        check_output("fault_exit_fault", int'(fault), 0);
        check_output("fault_exit_code", int'(fault_code), 0);
        go_off();

        // Orderly shutdown; request comes back mid-way and must not abort it.
        apply_stimulus(vecs[0].dly);
        pwr_on_req = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            @(posedge clk); #1;
            if (i == 3) rail_pwrgd[3] = 1'b0;
            if (i == 8) pwr_on_req = 1'b1;
            if (i == 16) rail_pwrgd = '0;
            if (i <= 21)
                check_output($sformatf("off_rail_en_%0d", i), int'(rail_en),
                             (i < 6) ? 7 : (i < 11) ? 3 : (i < 16) ? 1 : 0);
            if (i == 1) check_output("off_pwrok_lag", int'(sys_pwrok), 1);
            if (i == 2) check_output("off_pwrok_fall", int'(sys_pwrok), 0);
            if (i == 20) check_output("off_state_20", int'(seq_fsm), 4);
            if (i == 21) check_output("off_state_21", int'(seq_fsm), 0);
            if (i == 22) begin
                check_output("restart_state", int'(seq_fsm), 1);
                check_output("restart_rail_en", int'(rail_en), 1);
            end
        end
        go_off();

        // Active-sleep-well loss while waiting on rail 1.
        pwr_on_req = 1'b1;
        @(posedge clk); #1;
        check_output("asw_en0", int'(rail_en), 1);
        repeat (3) @(posedge clk);
        #1;
        rail_pwrgd[0] = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check_output("asw_en1", int'(rail_en), 3);
        check_output("asw_wait_state", int'(seq_fsm), 1);
        repeat (2) @(posedge clk);
        #1;
        asw_ok = 1'b0;
        @(posedge clk); #1;
        check_output("asw_rail_en", int'(rail_en), 0);
        check_output("asw_state", int'(seq_fsm), 0);
        check_output("asw_fault", int'(fault), 0);
        go_off();

        // Asynchronous reset while on.
        apply_stimulus(vecs[0].dly);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        pwr_on_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        go_off();

        for (int trial = 0; trial < 30; trial++) begin
            for (int k = 0; k < N; k++)
                rdly[k] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(95, 105))
                                                      : 8'($urandom_range(0, 12));
            model_powerup(rdly);
            apply_stimulus(rdly);
            check_outcome($sformatf("rand%0d", trial), exp_fault, exp_rail, exp_end);
            for (int k = 0; k < N; k++)
                check_output($sformatf("rand%0d_en%0d_t", trial, k), act_en_t[k], exp_en_t[k]);
            go_off();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rail_seq_ctrl.md
# rail_seq_ctrl

Main-rail power sequencer. Once the active-sleep well reports good, it brings up N downstream rails in a fixed order and supervises their power-good inputs. It shuts them down in reverse order, or kills them all at once on a fault. It sits in the power-sequencing hierarchy beside the active-sleep-well block, consumes that block's good output, and drives rail enables plus an aggregate system power-ok.

## Interface
- N_RAILS, 4: number of sequenced rails (2..8); index 0 comes up first.
- T_PG_TO, 100: clocks allowed in WAIT_PG for the current rail's pwrgd before timeout.
- T_ON_DLY, 10: clocks between a rail's pwrgd and the next rail's enable.
- T_OFF_DLY, 5: clocks between successive rail disables in SHUTDOWN.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- asw_ok  in  1  active-sleep-well good; prerequisite for sequencing.
- pwr_on_req  in  1  level request for main power on.
- rail_pwrgd  in  N_RAILS  per-rail power-good, already synchronous to clk.
- rail_en  out  N_RAILS  per-rail enable, registered.
- sys_pwrok  out  1  all rails up, registered.
- fault  out  1  latched fault flag, registered.
- fault_code  out  2  0 none, 1 pwrgd timeout, 2 pwrgd drop, 3 reserved.
- fault_rail  out  3  index of the faulting rail.
- seq_fsm  out  3  current state, debug.

## Operation
- States: OFF=0, WAIT_PG=1, ON_DLY=2, ON=3, SHUTDOWN=4, FAULT=5.
- Internal rail index idx, reset 0. One shared cycle timer, cleared on every state entry and on every idx change.
- Priority, evaluated every cycle from highest: asw_ok low, then fault detect, then pwr_on_req low.
  - asw_ok low in any state except OFF: go to OFF, clear all rail_en on the same edge. fault keeps its value.
- OFF:
  - rail_en=0 and idx=0.
  - pwr_on_req && asw_ok: go to WAIT_PG and set rail_en[0].
- WAIT_PG:
  - rail_pwrgd[idx] high: if idx==N_RAILS-1, go to ON; otherwise go to ON_DLY.
  - Timer reaches T_PG_TO-1 without pwrgd: go to FAULT with code 1 and rail=idx.
- ON_DLY:
  - Timer reaches T_ON_DLY-1: increment idx, set rail_en[idx], go to WAIT_PG.
- Drop check in WAIT_PG, ON_DLY and ON: an already-good rail j (j<idx, or j<=idx in ON_DLY and ON) losing pwrgd goes to FAULT with code 2 and rail = lowest such j.
- ON: no further transitions except through the priority list.
- pwr_on_req low in WAIT_PG, ON_DLY or ON: go to SHUTDOWN.
  - idx is set to the highest enabled rail.
  - rail_en[idx] is cleared on the entry edge.
- SHUTDOWN:
  - Every T_OFF_DLY clocks: decrement idx and clear rail_en[idx].
  - After the interval that follows clearing rail 0: go to OFF.
  - pwr_on_req reasserting does not abort the shutdown; OFF restarts the sequence.
  - pwrgd drops are ignored.
- FAULT:
  - All rail_en are cleared on the entry edge.
  - fault=1, and fault_code and fault_rail are captured on the same edge.
  - Exits to OFF only when pwr_on_req is low. fault, code and rail clear on that exit edge.

## Timing
- Reset values: rail_en=0, sys_pwrok=0, fault=0, fault_code=0, fault_rail=0, seq_fsm=OFF, idx=0.
- rail_en[k] rises on the same edge the FSM enters WAIT_PG for k.
- pwrgd seen in cycle c is acted on at edge c+1.
- Next enable follows pwrgd-detect by T_ON_DLY+1 edges.
- sys_pwrok = registered (state==ON); rises one clock after ON entry and falls one clock after leaving ON.
- Timeout: FAULT is entered exactly T_PG_TO edges after rail_en[idx] rose if pwrgd never arrives. pwrgd arriving in the final cycle wins.
- Timer width: clog2 of max(T_PG_TO, T_ON_DLY, T_OFF_DLY)+1 bits; saturates and never wraps.
- Mid-operation reset: outputs go to reset values immediately and asynchronously.

## Structure
- The shared power-sequencing package holds:
  - the state enum (3-bit);
  - the fault_code enum;
  - default timing constants.
- One sub-module, seq_timer: a clear/enable cycle counter with a terminal-count compare against a runtime limit input. The FSM selects the limit per state.

## Test plan
Parameters: N_RAILS=4, T_PG_TO=100, T_ON_DLY=10, T_OFF_DLY=5.
1. Nominal up: asw_ok=1, pwr_on_req=1, each pwrgd returned 3 clocks after its enable -> rail_en goes 0001, 0011, 0111, 1111 with 14 clocks between enables; sys_pwrok=1 one clock after ON entry.
2. Timeout: rail 2 pwrgd held low -> FAULT 100 clocks after rail_en[2] rose, rail_en=0000, fault_code=1, fault_rail=2; fault clears only after pwr_on_req=0.
3. Drop in ON: rail 1 pwrgd low for 1 clock -> next edge rail_en=0000, fault_code=2, fault_rail=1, sys_pwrok low one clock later.
4. Orderly off: from ON, pwr_on_req=0 -> rail_en 0111, 0011, 0001, 0000 at 5-clock spacing, then OFF after 5 more clocks.
5. asw_ok loss mid-WAIT_PG for rail 1 -> rail_en=0000 and state OFF on the next edge, fault stays 0.
6. Async reset asserted in ON -> all outputs at reset values before the next clk edge.
